// File: rtl/vga_sram_pkg.sv
//==============================================================================
// Module      : vga_sram_pkg
// Description : Shared types and constants for the VGA SRAM bridge.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package vga_sram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic        c_pad_idle_n        = 1'b1;
  localparam logic        c_dq_oe_idle        = 1'b0;
  localparam int          c_rd_latency        = 2;
  localparam logic [15:0] c_clr_value_default = 16'h0720;

endpackage

`default_nettype wire

// File: rtl/vga_sram_clr_seq.sv
//==============================================================================
// Module      : vga_sram_clr_seq
// Description : Post-reset clear address counter with active and done flags.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module vga_sram_clr_seq
  import vga_sram_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   limit,
  output logic [AW-1:0] addr,
  output logic          active,
  output logic          done
);

  // One extra counter bit so a full 2^AW clear does not wrap.
  logic [AW:0] r_cnt;
  state_e      r_state;
  logic        r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= (limit == '0) ? RUN : CLEAR;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == RUN);
      if (r_state == CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == limit - 1'b1) begin
          r_state <= RUN;
        end
      end
    end
  end

  assign addr   = r_cnt[AW-1:0];
  assign active = (r_state == CLEAR);
  assign done   = r_done;

endmodule

`default_nettype wire

// File: rtl/vga_sram_bridge.sv
//==============================================================================
// Module      : vga_sram_bridge
// Description : CSR master to 16-bit async SRAM bridge with post-reset clear.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module vga_sram_bridge
  import vga_sram_pkg::*;
#(
  parameter int          AW        = 17,
  parameter int          CLR_WORDS = 131072,
  parameter logic [15:0] CLR_VALUE = c_clr_value_default
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [AW-1:0] csrm_adr_o,
  input  logic [1:0]    csrm_sel_o,
  input  logic          csrm_we_o,
  input  logic [15:0]   csrm_dat_o,
  output logic [15:0]   csrm_dat_i,
  output logic          init_done,
  output logic [AW-1:0] sram_addr,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n,
  output logic [15:0]   sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [15:0]   sram_dq_i
);

  localparam logic [AW:0] c_clr_limit = (AW+1)'(CLR_WORDS);

  logic [AW-1:0] w_clr_addr;
  logic          w_clr_active;
  logic          w_clr_done;
  logic          w_wr;

  vga_sram_clr_seq #(
    .AW (AW)
  ) u_clr_seq (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .limit  (c_clr_limit),
    .addr   (w_clr_addr),
    .active (w_clr_active),
    .done   (w_clr_done)
  );

  // A write with no byte lanes selected degrades to a read.
  assign w_wr = csrm_we_o & (|csrm_sel_o);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      sram_addr  <= '0;
      sram_ce_n  <= c_pad_idle_n;
      sram_oe_n  <= c_pad_idle_n;
      sram_we_n  <= c_pad_idle_n;
      sram_ub_n  <= c_pad_idle_n;
      sram_lb_n  <= c_pad_idle_n;
      sram_dq_o  <= '0;
      sram_dq_oe <= c_dq_oe_idle;
      csrm_dat_i <= '0;
    end else if (w_clr_active) begin
      sram_addr  <= w_clr_addr;
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b0;
      sram_ub_n  <= 1'b0;
      sram_lb_n  <= 1'b0;
      sram_dq_o  <= CLR_VALUE;
      sram_dq_oe <= 1'b1;
      csrm_dat_i <= '0;
    end else begin
      sram_addr  <= csrm_adr_o;
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= w_wr;
      sram_we_n  <= ~w_wr;
      sram_dq_oe <= w_wr;
      sram_ub_n  <= w_wr & ~csrm_sel_o[1];
      sram_lb_n  <= w_wr & ~csrm_sel_o[0];
      if (w_wr) begin
        sram_dq_o <= csrm_dat_o;
      end
      // oe_n low marks the pad cycle that just ended as a read.
      if (!sram_oe_n) begin
        csrm_dat_i <= sram_dq_i;
      end
    end
  end

  assign init_done = w_clr_done;

endmodule

`default_nettype wire

// File: tb/tb_vga_sram_bridge.sv
//==============================================================================
// Module      : tb_vga_sram_bridge
// Description : Scoreboard bench for vga_sram_bridge with an async SRAM model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_vga_sram_bridge;

  localparam int AW = 17;

  typedef struct {
    int          due;
    logic [AW-1:0] addr;
    logic [6:0]  ctl;   // {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, init_done}
    logic        chk_dq;
    logic [15:0] dq;
  } pad_t;

  typedef struct {
    int          due;
    logic [15:0] val;
  } rd_t;

  localparam logic [6:0] CTL_RESET = 7'b1111100;
  localparam logic [6:0] CTL_CLEAR = 7'b0100010;
  localparam logic [6:0] CTL_READ  = 7'b0010001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] adr;
  logic [1:0]    sel;
  logic          we;
  logic [15:0]   wdat;

  logic [15:0]   dat_i, dq_o, dq_i;
  logic          init_done, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;
  logic [AW-1:0] s_addr;

  logic [15:0]   z_dat_i, z_dq_o;
  logic          z_init_done, z_ce_n, z_oe_n, z_we_n, z_ub_n, z_lb_n, z_dq_oe;
  logic [AW-1:0] z_addr;

  vga_sram_bridge #(.AW(AW), .CLR_WORDS(4), .CLR_VALUE(16'h0720)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .csrm_adr_o(adr), .csrm_sel_o(sel), .csrm_we_o(we), .csrm_dat_o(wdat),
    .csrm_dat_i(dat_i), .init_done(init_done),
    .sram_addr(s_addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n), .sram_dq_o(dq_o), .sram_dq_oe(dq_oe),
    .sram_dq_i(dq_i)
  );

  vga_sram_bridge #(.AW(AW), .CLR_WORDS(0), .CLR_VALUE(16'h0720)) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .csrm_adr_o(adr), .csrm_sel_o(sel), .csrm_we_o(we), .csrm_dat_o(wdat),
    .csrm_dat_i(z_dat_i), .init_done(z_init_done),
    .sram_addr(z_addr), .sram_ce_n(z_ce_n), .sram_oe_n(z_oe_n), .sram_we_n(z_we_n),
    .sram_ub_n(z_ub_n), .sram_lb_n(z_lb_n), .sram_dq_o(z_dq_o), .sram_dq_oe(z_dq_oe),
    .sram_dq_i(16'h0000)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pad_t padq[$];
  rd_t  rdq[$];

  logic [15:0] mem  [int];
  logic [15:0] refm [int];
  logic [15:0] last_rd = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] memget(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 16'h0000;
  endfunction

  function automatic logic [15:0] refget(input logic [AW-1:0] a);
    return refm.exists(int'(a)) ? refm[int'(a)] : 16'h0000;
  endfunction

  // Asynchronous SRAM: writes land at the end of a write pad cycle, read data
  // settles mid-cycle so it is stable at the capturing edge.
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      logic [15:0] v;
      v = memget(s_addr);
      if (!ub_n) v[15:8] = dq_o[15:8];
      if (!lb_n) v[7:0]  = dq_o[7:0];
      mem[int'(s_addr)] = v;
    end
  end

  always @(negedge clk) begin
    dq_i = (!ce_n && !oe_n) ? memget(s_addr) : 16'h0000;
  end

  task automatic push_pad(input int due, input logic [AW-1:0] a, input logic [6:0] ctl,
                          input logic cd, input logic [15:0] d);
    pad_t e;
    e.due = due; e.addr = a; e.ctl = ctl; e.chk_dq = cd; e.dq = d;
    padq.push_back(e);
  endtask

  task automatic push_rd(input int due, input logic [15:0] v);
    rd_t r;
    r.due = due; r.val = v;
    rdq.push_back(r);
  endtask

  task automatic access(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                        input logic [15:0] d);
    logic [15:0] v;
    we = w; sel = s; adr = a; wdat = d;
    if (w && (s != 2'b00)) begin
      v = refget(a);
      if (s[1]) v[15:8] = d[15:8];
      if (s[0]) v[7:0]  = d[7:0];
      refm[int'(a)] = v;
      push_pad(cyc + 1, a, {1'b0, 1'b1, 1'b0, ~s[1], ~s[0], 1'b1, 1'b1}, 1'b1, d);
    end else begin
      last_rd = refget(a);
      push_pad(cyc + 1, a, CTL_READ, 1'b0, 16'h0000);
    end
    push_rd(cyc + 2, last_rd);
    @(negedge clk);
  endtask

  // Releases reset with junk on csrm; the clear sequence must ignore it.
  task automatic release_clear(input int n);
    rst_n = 1'b1; we = 1'b1; sel = 2'b11; adr = '1; wdat = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      push_pad(cyc + 1 + i, AW'(i), CTL_CLEAR, 1'b1, 16'h0720);
      refm[i] = 16'h0720;
    end
    for (int i = 1; i <= n + 1; i++) push_rd(cyc + i, 16'h0000);
    last_rd = 16'h0000;
  endtask

  task automatic assert_reset();
    int lim;
    lim = cyc + 1;
    rst_n = 1'b0;
    while (padq.size() > 0 && padq[$].due >= lim) void'(padq.pop_back());
    while (rdq.size() > 0 && rdq[$].due >= lim) void'(rdq.pop_back());
    push_pad(lim, '0, CTL_RESET, 1'b1, 16'h0000);
    push_rd(lim, 16'h0000);
  endtask

  always @(posedge clk) begin
    pad_t e;
    rd_t  r;
    cyc++;
    #1;
    if (cyc > 2) chk("turnaround", {31'd0, (~oe_n) & dq_oe}, 32'd0);
    while (padq.size() > 0 && padq[0].due <= cyc) begin
      e = padq.pop_front();
      if (e.due < cyc) begin
        chk("pad_due", e.due, cyc);
      end else begin
        chk("pad_ctl", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, init_done}, e.ctl);
        chk("pad_addr", s_addr, e.addr);
        if (e.chk_dq) chk("pad_dq", dq_o, e.dq);
      end
    end
    while (rdq.size() > 0 && rdq[0].due <= cyc) begin
      r = rdq.pop_front();
      if (r.due < cyc) chk("rd_due", r.due, cyc);
      else             chk("rd_data", dat_i, r.val);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; sel = 2'b00; adr = '0; wdat = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, init_done}, CTL_RESET);
    chk("rst_addr", s_addr, 0);
    chk("rst_dq", dq_o, 0);
    chk("rst_dat", dat_i, 0);
    chk("rst0_ctl", {z_ce_n, z_oe_n, z_we_n, z_ub_n, z_lb_n, z_dq_oe, z_init_done}, CTL_RESET);

    release_clear(4);
    @(negedge clk);
    chk("zero_clr_done", {31'd0, z_init_done}, 32'd1);
    chk("zero_clr_ce", {31'd0, z_ce_n}, 32'd0);
    repeat (3) @(negedge clk);

    access(1'b1, 2'b11, 17'h00010, 16'h1234);
    access(1'b0, 2'b00, 17'h00010, 16'h0000);
    access(1'b1, 2'b01, 17'h00020, 16'hABCD);
    access(1'b1, 2'b00, 17'h00030, 16'h9999);
    access(1'b0, 2'b11, 17'h00020, 16'h0000);
    access(1'b1, 2'b11, 17'h1FFFF, 16'hBEEF);
    access(1'b0, 2'b00, 17'h1FFFF, 16'h0000);
    access(1'b1, 2'b10, 17'h00000, 16'h0102);
    access(1'b0, 2'b00, 17'h1FFFF, 16'h0000);
    access(1'b1, 2'b11, 17'h00000, 16'h5555);
    access(1'b0, 2'b00, 17'h00000, 16'h0000);
    access(1'b1, 2'b11, 17'h00040, 16'h7777);

    assert_reset();
    @(negedge clk);
    release_clear(4);
    repeat (2) @(negedge clk);
    assert_reset();
    @(negedge clk);
    release_clear(4);
    repeat (4) @(negedge clk);

    access(1'b0, 2'b00, 17'h00003, 16'h0000);
    access(1'b0, 2'b00, 17'h00000, 16'h0000);
    access(1'b0, 2'b00, 17'h00010, 16'h0000);
    access(1'b1, 2'b11, 17'h00050, 16'h2468);

    for (int i = 0; i < 20 && (padq.size() + rdq.size()) > 0; i++) @(negedge clk);
    chk("drain", padq.size() + rdq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
